// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, ALU codes, sequencer states and instruction classes for control_unit
package cpu_pkg;
  localparam logic [4:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2, OP_ADD = 5'd3, OP_SUB = 5'd4;
  localparam logic [4:0] OP_SHR = 5'd5, OP_SHL = 5'd6, OP_ROR = 5'd7, OP_ROL = 5'd8, OP_AND = 5'd9;
  localparam logic [4:0] OP_OR = 5'd10, OP_ADDI = 5'd11, OP_ANDI = 5'd12, OP_ORI = 5'd13;
  localparam logic [4:0] OP_MUL = 5'd14, OP_DIV = 5'd15, OP_NEG = 5'd16, OP_NOT = 5'd17;
  localparam logic [4:0] OP_BR = 5'd18, OP_JR = 5'd19, OP_JAL = 5'd20, OP_IN = 5'd21, OP_OUT = 5'd22;
  localparam logic [4:0] OP_MFHI = 5'd23, OP_MFLO = 5'd24, OP_NOP = 5'd25, OP_HALT = 5'd26;
  localparam logic [4:0] ALU_ADD = 5'b00011, ALU_AND = 5'b01001, ALU_OR = 5'b01010, ALU_INC = 5'b11111;
  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;
  typedef enum logic [3:0] {
    C_ALU3, C_ALUI, C_LDI, C_LD, C_ST, C_MULDIV, C_UNARY, C_BR,
    C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } iclass_t;
endpackage

// File: rtl/opcode_decoder.sv
// opcode_decoder: maps an opcode to its instruction class, ALU operation and final execute state
import cpu_pkg::*;
module opcode_decoder (
  input  logic [4:0] op,
  output iclass_t    cls,
  output logic [4:0] alu,
  output state_t     last
);
  always_comb begin
    cls = C_HALT;
    case (op) inside
      OP_LD: cls = C_LD;
      OP_LDI: cls = C_LDI;
      OP_ST: cls = C_ST;
      [OP_ADD:OP_OR]: cls = C_ALU3;
      [OP_ADDI:OP_ORI]: cls = C_ALUI;
      OP_MUL, OP_DIV: cls = C_MULDIV;
      OP_NEG, OP_NOT: cls = C_UNARY;
      OP_BR: cls = C_BR;
      OP_JR: cls = C_JR;
      OP_JAL: cls = C_JAL;
      OP_IN: cls = C_IN;
      OP_OUT: cls = C_OUT;
      OP_MFHI: cls = C_MFHI;
      OP_MFLO: cls = C_MFLO;
      OP_NOP: cls = C_NOP;
      default: cls = C_HALT;
    endcase
  end
  assign alu = cls == C_ALUI ? (op == OP_ADDI ? ALU_ADD : op == OP_ANDI ? ALU_AND : ALU_OR) :
               cls inside {C_ALU3, C_MULDIV, C_UNARY} ? op : ALU_ADD;
  // halting classes never reach an active last state, so instr_done stays low for them
  always_comb begin
    last = S_T3;
    case (cls)
      C_ALU3, C_ALUI, C_LDI: last = S_T5;
      C_LD, C_ST: last = S_T7;
      C_MULDIV, C_BR: last = S_T6;
      C_UNARY, C_JAL: last = S_T4;
      C_HALT: last = S_HALT;
      default: last = S_T3;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/execute sequencer driving the single-bus datapath strobes
import cpu_pkg::*;
module control_unit #(
  parameter int IR_OP_MSB = 31
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        ConOut,
  output logic        HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn,
  output logic        HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut,
  output logic        Gra, Grb, Grc, RIn, ROut, BAOut, Conin,
  output logic        memread, memwrite,
  output logic [4:0]  ALUCode,
  output logic        run,
  output logic        instr_done,
  output logic [3:0]  t_state
);
  state_t state, state_nx, last;
  iclass_t cls;
  logic [4:0] alu;
  logic unused_ir;
  assign unused_ir = ^ir;
  opcode_decoder u_dec (.op(ir[IR_OP_MSB -: 5]), .cls(cls), .alu(alu), .last(last));
  always_ff @(posedge clock or posedge clear)
    if (clear) state <= S_RESET;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_RESET: state_nx = S_T0;
      S_T2: state_nx = cls == C_HALT ? S_HALT : S_T3;
      S_HALT: state_nx = S_HALT;
      default: state_nx = state == last ? S_T0 : state_t'(state + 4'd1);
    endcase
  end
  assign run = state != S_RESET && state != S_HALT;
  assign instr_done = run && state == last;
  assign t_state = state;
  always_comb begin
    {HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn} = '0;
    {HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut} = '0;
    {Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite} = '0;
    ALUCode = '0;
    case (state)
      S_T0: begin PCOut = 1'b1; MARIn = 1'b1; ZIn = 1'b1; ALUCode = ALU_INC; end
      S_T1: begin ZLoOut = 1'b1; PCIn = 1'b1; memread = 1'b1; MDRIn = 1'b1; end
      S_T2: begin MDROut = 1'b1; IRIn = 1'b1; end
      S_T3: case (cls)
        C_ALU3, C_ALUI: begin Grb = 1'b1; ROut = 1'b1; YIn = 1'b1; end
        C_LDI, C_LD, C_ST: begin Grb = 1'b1; BAOut = 1'b1; YIn = 1'b1; end
        C_MULDIV: begin Gra = 1'b1; ROut = 1'b1; YIn = 1'b1; end
        C_UNARY: begin Grb = 1'b1; ROut = 1'b1; ALUCode = alu; ZIn = 1'b1; end
        C_BR: begin Gra = 1'b1; ROut = 1'b1; Conin = 1'b1; end
        C_JR: begin Gra = 1'b1; ROut = 1'b1; PCIn = 1'b1; end
        C_JAL: begin PCOut = 1'b1; Grb = 1'b1; RIn = 1'b1; end
        C_IN: begin IPortOut = 1'b1; Gra = 1'b1; RIn = 1'b1; end
        C_OUT: begin Gra = 1'b1; ROut = 1'b1; OPortIn = 1'b1; end
        C_MFHI: begin HiOut = 1'b1; Gra = 1'b1; RIn = 1'b1; end
        C_MFLO: begin LoOut = 1'b1; Gra = 1'b1; RIn = 1'b1; end
        default: ;
      endcase
      S_T4: case (cls)
        C_ALU3: begin Grc = 1'b1; ROut = 1'b1; ALUCode = alu; ZIn = 1'b1; end
        C_ALUI, C_LDI, C_LD, C_ST: begin COut = 1'b1; ALUCode = alu; ZIn = 1'b1; end
        C_MULDIV: begin Grb = 1'b1; ROut = 1'b1; ALUCode = alu; ZIn = 1'b1; end
        C_UNARY: begin ZLoOut = 1'b1; Gra = 1'b1; RIn = 1'b1; end
        C_BR: begin PCOut = 1'b1; YIn = 1'b1; end
        C_JAL: begin Gra = 1'b1; ROut = 1'b1; PCIn = 1'b1; end
        default: ;
      endcase
      S_T5: case (cls)
        C_ALU3, C_ALUI, C_LDI: begin ZLoOut = 1'b1; Gra = 1'b1; RIn = 1'b1; end
        C_LD, C_ST: begin ZLoOut = 1'b1; MARIn = 1'b1; end
        C_MULDIV: begin ZLoOut = 1'b1; LoIn = 1'b1; end
        C_BR: begin COut = 1'b1; ALUCode = alu; ZIn = 1'b1; end
        default: ;
      endcase
      S_T6: case (cls)
        C_LD: begin memread = 1'b1; MDRIn = 1'b1; end
        C_ST: begin Gra = 1'b1; ROut = 1'b1; MDRIn = 1'b1; end
        C_MULDIV: begin ZHiOut = 1'b1; HiIn = 1'b1; end
        C_BR: begin ZLoOut = ConOut; PCIn = ConOut; end
        default: ;
      endcase
      S_T7: case (cls)
        C_LD: begin MDROut = 1'b1; Gra = 1'b1; RIn = 1'b1; end
        C_ST: memwrite = 1'b1;
        default: ;
      endcase
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized instruction stream checked through a scoreboard against a step-table model
module tb_control_unit;
  logic clock = 1'b0, clear = 1'b1, ConOut = 1'b0;
  logic [31:0] ir = '0;
  logic HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn;
  logic HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut;
  logic Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite;
  logic [4:0] ALUCode;
  logic run, instr_done;
  logic [3:0] t_state;
  localparam logic [25:0] HIIN = 26'd1 << 0, LOIN = 26'd1 << 1, ZIN = 26'd1 << 2, PCIN = 26'd1 << 3;
  localparam logic [25:0] MDRIN = 26'd1 << 4, MARIN = 26'd1 << 5, YIN = 26'd1 << 6, OPORTIN = 26'd1 << 7;
  localparam logic [25:0] IRIN = 26'd1 << 8, HIOUT = 26'd1 << 9, LOOUT = 26'd1 << 10, ZHIOUT = 26'd1 << 11;
  localparam logic [25:0] ZLOOUT = 26'd1 << 12, PCOUT = 26'd1 << 13, MDROUT = 26'd1 << 14, IPORTOUT = 26'd1 << 15;
  localparam logic [25:0] COUT = 26'd1 << 16, GRA = 26'd1 << 17, GRB = 26'd1 << 18, GRC = 26'd1 << 19;
  localparam logic [25:0] RIN = 26'd1 << 20, ROUT = 26'd1 << 21, BAOUT = 26'd1 << 22, CONIN = 26'd1 << 23;
  localparam logic [25:0] MEMREAD = 26'd1 << 24, MEMWRITE = 26'd1 << 25;

  control_unit dut (
    .clock(clock), .clear(clear), .ir(ir), .ConOut(ConOut),
    .HiIn(HiIn), .LoIn(LoIn), .ZIn(ZIn), .PCIn(PCIn), .MDRIn(MDRIn), .MARIn(MARIn), .YIn(YIn),
    .OPortIn(OPortIn), .IRIn(IRIn), .HiOut(HiOut), .LoOut(LoOut), .ZHiOut(ZHiOut), .ZLoOut(ZLoOut),
    .PCOut(PCOut), .MDROut(MDROut), .IPortOut(IPortOut), .COut(COut), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .RIn(RIn), .ROut(ROut), .BAOut(BAOut), .Conin(Conin), .memread(memread), .memwrite(memwrite),
    .ALUCode(ALUCode), .run(run), .instr_done(instr_done), .t_state(t_state)
  );

  always #5 clock = ~clock;

  logic [25:0] strobes;
  logic [32:0] obs;
  assign strobes = {memwrite, memread, Conin, BAOut, ROut, RIn, Grc, Grb, Gra, COut, IPortOut, MDROut,
                    PCOut, ZLoOut, ZHiOut, LoOut, HiOut, IRIn, OPortIn, YIn, MARIn, MDRIn, PCIn, ZIn, LoIn, HiIn};
  assign obs = {instr_done, run, ALUCode, strobes};

  typedef struct {
    logic [32:0] v;
    bit rst;
    string name;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int errors = 0, checks = 0;

  // cycles per instruction including the three fetch states; halting opcodes only fetch
  function automatic int len(input int op);
    if (op <= 2) return op == 1 ? 6 : 8;
    if (op <= 13) return 6;
    if (op <= 15) return 7;
    if (op <= 17) return 5;
    if (op == 18) return 7;
    if (op == 20) return 5;
    if (op <= 25) return 4;
    return 3;
  endfunction

  function automatic logic [32:0] model(input int op, input int k, input logic con);
    logic [25:0] s;
    logic [4:0] a;
    int e2;
    s = '0; a = '0; e2 = k - 3;
    if (k == 0) begin s = PCOUT | MARIN | ZIN; a = 5'b11111; end
    else if (k == 1) s = ZLOOUT | PCIN | MEMREAD | MDRIN;
    else if (k == 2) s = MDROUT | IRIN;
    else if (op >= 3 && op <= 13) begin
      if (e2 == 0) s = GRB | ROUT | YIN;
      else if (e2 == 1) begin
        s = (op <= 10 ? GRC | ROUT : COUT) | ZIN;
        a = op <= 10 ? 5'(op) : op == 11 ? 5'b00011 : op == 12 ? 5'b01001 : 5'b01010;
      end
      else s = ZLOOUT | GRA | RIN;
    end
    else if (op <= 2) begin
      if (e2 == 0) s = GRB | BAOUT | YIN;
      else if (e2 == 1) begin s = COUT | ZIN; a = 5'b00011; end
      else if (e2 == 2) s = op == 1 ? ZLOOUT | GRA | RIN : ZLOOUT | MARIN;
      else if (e2 == 3) s = op == 0 ? MEMREAD | MDRIN : GRA | ROUT | MDRIN;
      else s = op == 0 ? MDROUT | GRA | RIN : MEMWRITE;
    end
    else if (op == 14 || op == 15) begin
      if (e2 == 0) s = GRA | ROUT | YIN;
      else if (e2 == 1) begin s = GRB | ROUT | ZIN; a = 5'(op); end
      else if (e2 == 2) s = ZLOOUT | LOIN;
      else s = ZHIOUT | HIIN;
    end
    else if (op == 16 || op == 17) begin
      if (e2 == 0) begin s = GRB | ROUT | ZIN; a = 5'(op); end
      else s = ZLOOUT | GRA | RIN;
    end
    else if (op == 18) begin
      if (e2 == 0) s = GRA | ROUT | CONIN;
      else if (e2 == 1) s = PCOUT | YIN;
      else if (e2 == 2) begin s = COUT | ZIN; a = 5'b00011; end
      else s = con ? ZLOOUT | PCIN : '0;
    end
    else if (op == 19) s = GRA | ROUT | PCIN;
    else if (op == 20) s = e2 == 0 ? PCOUT | GRB | RIN : GRA | ROUT | PCIN;
    else if (op == 21) s = IPORTOUT | GRA | RIN;
    else if (op == 22) s = GRA | ROUT | OPORTIN;
    else if (op == 23) s = HIOUT | GRA | RIN;
    else if (op == 24) s = LOOUT | GRA | RIN;
    return {k == len(op) - 1 && op <= 25, 1'b1, a, s};
  endfunction

  task automatic push(input logic [32:0] v, input bit r, input string n);
    exp_t x;
    x.v = v; x.rst = r; x.name = n;
    q.push_back(x);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // asserts clear mid-cycle, holds it for n cycles, then releases it; the release cycle is still idle
  task automatic do_reset(input int n);
    clear = 1'b1;
    push('0, 1'b1, "reset");
    repeat (n - 1) begin cyc(); push('0, 1'b1, "reset"); end
    cyc();
    clear = 1'b0;
    push('0, 1'b1, "reset_release");
  endtask

  // cmode: 0/1 fixed ConOut, 2 random per cycle; abort: step at which clear is raised (-1 = none)
  task automatic run_ir(input logic [31:0] v, input int cmode, input int abort, input string n);
    int op, l;
    op = int'(v[31:27]);
    l = len(op);
    for (int k = 0; k < l; k++) begin
      cyc();
      if (k == abort) begin do_reset(2); return; end
      ir = v;
      ConOut = cmode == 2 ? 1'($urandom_range(0, 1)) : cmode[0];
      push(model(op, k, ConOut), 1'b0, n);
    end
  endtask

  initial forever begin
    @(negedge clock);
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s: got %h want %h at %0t", e.name, obs, e.v, $time);
      end
      if (e.rst) begin
        checks++;
        if (t_state !== 4'd0) begin
          errors++;
          $display("FAIL %s t_state: got %0d want 0", e.name, t_state);
        end
      end
    end
  end

  initial begin
    int op;
    cyc();
    do_reset(2);
    run_ir(32'h0900_0078, 2, -1, "ldi");
    run_ir(32'h0088_0054, 2, -1, "ld");
    run_ir(32'h1088_0087, 2, -1, "st");
    run_ir(32'h9000_0000, 0, -1, "br_con0");
    run_ir(32'h9000_0000, 1, -1, "br_con1");
    run_ir(32'h7000_0000, 2, -1, "mul");
    run_ir(32'h1800_0000, 2, 4, "add_abort");
    run_ir(32'h0900_0078, 2, -1, "ldi_after_clear");
    repeat (60) begin
      op = $urandom_range(0, 25);
      run_ir({5'(op), 27'($urandom)}, 2, -1, "rand");
    end
    run_ir(32'hD000_0000, 2, -1, "halt");
    repeat (20) begin cyc(); ConOut = 1'($urandom_range(0, 1)); push('0, 1'b0, "halted"); end
    cyc();
    do_reset(2);
    run_ir({5'($urandom_range(27, 31)), 27'($urandom)}, 2, -1, "undef");
    repeat (5) begin cyc(); push('0, 1'b0, "undef_halted"); end
    cyc();
    do_reset(2);
    run_ir({5'd25, 27'($urandom)}, 2, -1, "nop");
    repeat (3) @(negedge clock);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
